// File: rtl/maxpool_fc_pkg.sv
// Shared constants, FSM encoding and helpers for the max-pool + binary FC block.
package maxpool_fc_pkg;

    localparam int FMAP_W  = 24;                 // conv2 map width/height (even)
    localparam int POOL_W  = FMAP_W / 2;         // pooled map width/height
    localparam int N_POOL  = POOL_W * POOL_W;    // pooled values per image
    localparam int N_CLASS = 10;                 // FC outputs
    localparam int ACC_W   = 10;                 // signed score width
    localparam int PIX_W   = 5;                  // signed conv2 sample width
    localparam int CNT_W   = $clog2(FMAP_W);     // row/col counter width
    localparam int LB_AW   = $clog2(POOL_W);     // line-buffer address width
    localparam int IDX_W   = 8;                  // pooled index / weight address width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Signed maximum of two samples.
    function automatic logic signed [PIX_W-1:0] smax(
        input logic signed [PIX_W-1:0] a,
        input logic signed [PIX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 max-pool over a raster-ordered map. Emits one
// binarised pooled value (1 when the window max is >= 0) per odd row/odd col.
module maxpool2x2_stream
    import maxpool_fc_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [PIX_W-1:0] din_i,
    output logic             pooled_valid_o,
    output logic             pooled_bit_o,
    output logic [IDX_W-1:0] pooled_idx_o
);

    logic [CNT_W-1:0]        col_q;
    logic [CNT_W-1:0]        row_q;
    logic signed [PIX_W-1:0] pair_q;
    logic signed [PIX_W-1:0] linebuf_q [POOL_W];

    logic [LB_AW-1:0]        lb_idx;
    logic [LB_AW-1:0]        row_half;
    logic signed [PIX_W-1:0] din_s;
    logic signed [PIX_W-1:0] lb_rd;
    logic signed [PIX_W-1:0] pm;
    logic signed [PIX_W-1:0] pooled;

    assign lb_idx   = col_q[CNT_W-1:1];
    assign row_half = row_q[CNT_W-1:1];
    assign din_s    = $signed(din_i);
    assign lb_rd    = linebuf_q[lb_idx];

    // Horizontal pair max, then vertical max against the stored upper row.
    assign pm     = smax(pair_q, din_s);
    assign pooled = smax(lb_rd, pm);

    assign pooled_valid_o = en_i & col_q[0] & row_q[0];
    assign pooled_bit_o   = ~pooled[PIX_W-1];
    assign pooled_idx_o   = IDX_W'(row_half) * IDX_W'(POOL_W) + IDX_W'(lb_idx);

    // Raster counters and the even-column hold register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q  <= '0;
            row_q  <= '0;
            pair_q <= '0;
        end else if (clear_i) begin
            col_q  <= '0;
            row_q  <= '0;
            pair_q <= '0;
        end else if (en_i) begin
            if (!col_q[0]) begin
                pair_q <= din_s;
            end
            if (col_q == CNT_W'(FMAP_W - 1)) begin
                col_q <= '0;
                row_q <= (row_q == CNT_W'(FMAP_W - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < POOL_W; gi++) begin : g_lb
            // Line-buffer entry: captures the horizontal max on even rows.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    linebuf_q[gi] <= '0;
                end else if (en_i && col_q[0] && !row_q[0] && lb_idx == LB_AW'(gi)) begin
                    linebuf_q[gi] <= pm;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/maxpool_fc.sv
// Max-pool front end feeding a 144->10 binary (XNOR, +-1) fully-connected layer.
// Owns the control FSM, weight-ROM address, accumulators and the done pulse.
module maxpool_fc
    import maxpool_fc_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         maxpool_valid,
    input  logic [4:0]   conv2_result_sum0,
    output logic [7:0]   fc_w_addr,
    input  logic [9:0]   fc_w_data,
    output logic [9:0]   fc_result_0,
    output logic [9:0]   fc_result_1,
    output logic [9:0]   fc_result_2,
    output logic [9:0]   fc_result_3,
    output logic [9:0]   fc_result_4,
    output logic [9:0]   fc_result_5,
    output logic [9:0]   fc_result_6,
    output logic [9:0]   fc_result_7,
    output logic [9:0]   fc_result_8,
    output logic [9:0]   fc_result_9,
    output logic         fc_result_valid
);

    state_e           state_q;
    logic [IDX_W-1:0] addr_q;
    logic             v1_q, v2_q;
    logic             bit1_q, bit2_q;
    logic             last1_q, last2_q;
    logic             valid_q;

    logic             pool_en;
    logic             pooled_valid;
    logic             pooled_bit;
    logic [IDX_W-1:0] pooled_idx;
    logic             pooled_last;
    logic [ACC_W-1:0] acc_bus [N_CLASS];

    // Samples are only accepted while running; start takes priority and drops the sample.
    assign pool_en     = (state_q == ST_RUN) && maxpool_valid && !start;
    assign pooled_last = pooled_valid && (pooled_idx == IDX_W'(N_POOL - 1));

    maxpool2x2_stream u_pool (
        .clk            (clk),
        .rstn           (rstn),
        .clear_i        (start),
        .en_i           (pool_en),
        .din_i          (conv2_result_sum0),
        .pooled_valid_o (pooled_valid),
        .pooled_bit_o   (pooled_bit),
        .pooled_idx_o   (pooled_idx)
    );

    // Control FSM plus the address/data alignment pipeline (address, ROM, accumulate).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            bit1_q  <= 1'b0;
            bit2_q  <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start) begin
                state_q <= ST_RUN;
                addr_q  <= '0;
                v1_q    <= 1'b0;
                v2_q    <= 1'b0;
                bit1_q  <= 1'b0;
                bit2_q  <= 1'b0;
                last1_q <= 1'b0;
                last2_q <= 1'b0;
            end else begin
                v1_q    <= pooled_valid;
                bit1_q  <= pooled_bit;
                last1_q <= pooled_last;
                if (pooled_valid) begin
                    addr_q <= pooled_idx;
                end
                v2_q    <= v1_q;
                bit2_q  <= bit1_q;
                last2_q <= last1_q;
                case (state_q)
                    ST_RUN: begin
                        if (pooled_last) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                    ST_FLUSH: begin
                        // Last product is accumulated on this edge; scores are final next cycle.
                        if (last2_q) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CLASS; gi++) begin : g_acc
            logic signed [ACC_W-1:0] acc_q;
            logic signed [ACC_W-1:0] step;

            assign step        = (bit2_q ~^ fc_w_data[gi]) ? ACC_W'(1) : '1;
            assign acc_bus[gi] = acc_q;

            // Per-class +-1 accumulation, one product per pooled value.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    acc_q <= '0;
                end else if (start) begin
                    acc_q <= '0;
                end else if (v2_q) begin
                    acc_q <= acc_q + step;
                end
            end
        end
    endgenerate

    assign fc_w_addr       = addr_q;
    assign fc_result_valid = valid_q;
    assign fc_result_0     = acc_bus[0];
    assign fc_result_1     = acc_bus[1];
    assign fc_result_2     = acc_bus[2];
    assign fc_result_3     = acc_bus[3];
    assign fc_result_4     = acc_bus[4];
    assign fc_result_5     = acc_bus[5];
    assign fc_result_6     = acc_bus[6];
    assign fc_result_7     = acc_bus[7];
    assign fc_result_8     = acc_bus[8];
    assign fc_result_9     = acc_bus[9];

endmodule

// File: tb/tb_maxpool_fc.sv
// Directed/random bench for maxpool_fc: golden-model scores go to a scoreboard
// when an image is driven and are checked when fc_result_valid pulses.
module tb_maxpool_fc;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       maxpool_valid = 1'b0;
    logic [4:0] conv2_result_sum0 = '0;
    logic [7:0] fc_w_addr;
    logic [9:0] fc_w_data;
    logic [9:0] fc_result_0, fc_result_1, fc_result_2, fc_result_3, fc_result_4;
    logic [9:0] fc_result_5, fc_result_6, fc_result_7, fc_result_8, fc_result_9;
    logic       fc_result_valid;

    always #5 clk = ~clk;

    maxpool_fc dut (
        .clk               (clk),
        .rstn              (rstn),
        .start             (start),
        .maxpool_valid     (maxpool_valid),
        .conv2_result_sum0 (conv2_result_sum0),
        .fc_w_addr         (fc_w_addr),
        .fc_w_data         (fc_w_data),
        .fc_result_0       (fc_result_0),
        .fc_result_1       (fc_result_1),
        .fc_result_2       (fc_result_2),
        .fc_result_3       (fc_result_3),
        .fc_result_4       (fc_result_4),
        .fc_result_5       (fc_result_5),
        .fc_result_6       (fc_result_6),
        .fc_result_7       (fc_result_7),
        .fc_result_8       (fc_result_8),
        .fc_result_9       (fc_result_9),
        .fc_result_valid   (fc_result_valid)
    );

    // Weight ROM with one cycle of read latency.
    logic [9:0] wmem [256];
    logic [9:0] rom_q;
    always @(posedge clk) rom_q <= wmem[fc_w_addr];
    assign fc_w_data = rom_q;

    logic [9:0] res [10];
    assign res[0] = fc_result_0;
    assign res[1] = fc_result_1;
    assign res[2] = fc_result_2;
    assign res[3] = fc_result_3;
    assign res[4] = fc_result_4;
    assign res[5] = fc_result_5;
    assign res[6] = fc_result_6;
    assign res[7] = fc_result_7;
    assign res[8] = fc_result_8;
    assign res[9] = fc_result_9;

    typedef struct { int s[10]; } exp_t;
    exp_t sb_q[$];
    exp_t last_exp;

    int img [576];
    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt = 0;
    logic log_en = 1'b0;
    int addr_log[$];

    always @(negedge clk) if (fc_result_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    always @(negedge clk) if (log_en) addr_log.push_back(int'(fc_w_addr));

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Golden model: 2x2 max, sign binarise, XNOR +-1 sum per class.
    task automatic push_golden();
        exp_t e;
        int   bitv [144];
        for (int p = 0; p < 144; p++) begin
            int r = p / 12;
            int c = p % 12;
            int m = img[(2*r)*24 + 2*c];
            if (img[(2*r)*24 + 2*c + 1] > m)   m = img[(2*r)*24 + 2*c + 1];
            if (img[(2*r+1)*24 + 2*c] > m)     m = img[(2*r+1)*24 + 2*c];
            if (img[(2*r+1)*24 + 2*c + 1] > m) m = img[(2*r+1)*24 + 2*c + 1];
            bitv[p] = (m >= 0) ? 1 : 0;
        end
        for (int k = 0; k < 10; k++) begin
            int s = 0;
            for (int p = 0; p < 144; p++) begin
                s += (bitv[p] == int'(wmem[p][k])) ? 1 : -1;
            end
            e.s[k] = s;
        end
        sb_q.push_back(e);
    endtask

    task automatic drive_sample(input int v);
        conv2_result_sum0 = 5'(v);
        maxpool_valid = 1'b1;
        @(negedge clk);
        maxpool_valid = 1'b0;
    endtask

    task automatic drive_image(input int gap_max, input int count);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            drive_sample(img[i]);
        end
    endtask

    task automatic do_start(input logic with_valid, input int v);
        start = 1'b1;
        maxpool_valid = with_valid;
        conv2_result_sum0 = 5'(v);
        @(negedge clk);
        start = 1'b0;
        maxpool_valid = 1'b0;
    endtask

    task automatic rand_image();
        for (int i = 0; i < 576; i++) img[i] = int'($urandom_range(31, 0)) - 16;
    endtask

    task automatic set_weights(input int mode);
        for (int p = 0; p < 256; p++) begin
            if (mode == 0) wmem[p] = 10'h3FF;
            else if (mode == 1) begin
                for (int k = 0; k < 10; k++) wmem[p][k] = 1'(((p >> (k % 8)) ^ (k / 8)) & 1);
            end else wmem[p] = 10'($urandom);
        end
    endtask

    // Wait (bounded) for the done pulse, then check scores against the scoreboard.
    task automatic wait_check(input string tag);
        int n = 0;
        while (fc_result_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (fc_result_valid !== 1'b1) begin
            chk({tag, " timeout"}, 0, 1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        if (sb_q.size() == 0) begin
            chk({tag, " unexpected pulse"}, 1, 0);
            return;
        end
        last_exp = sb_q.pop_front();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s score%0d", tag, k), int'($signed(res[k])), last_exp.s[k]);
        end
        @(negedge clk);
        chk({tag, " pulse width"}, int'(fc_result_valid), 0);
    endtask

    initial begin
        int p0;
        int seq[$];
        int err;

        for (int p = 0; p < 256; p++) wmem[p] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset valid", int'(fc_result_valid), 0);
        chk("reset addr", int'(fc_w_addr), 0);
        chk("reset score0", int'($signed(res[0])), 0);
        chk("reset score9", int'($signed(res[9])), 0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: all +5, weights all 1
        set_weights(0);
        for (int i = 0; i < 576; i++) img[i] = 5;
        p0 = pulse_cnt;
        do_start(1'b0, 0);
        push_golden();
        drive_image(0, 576);
        wait_check("t1");
        chk("t1 expect+144", last_exp.s[3], 144);
        repeat (3) @(negedge clk);
        chk("t1 pulses", pulse_cnt - p0, 1);

        // 2: all -1, weights all 1
        for (int i = 0; i < 576; i++) img[i] = -1;
        do_start(1'b0, 0);
        push_golden();
        drive_image(0, 576);
        wait_check("t2");
        chk("t2 expect-144", last_exp.s[0], -144);

        // 3: one sample of each window is the max; 0 vs -1 vs -16 decides the bit
        set_weights(1);
        for (int y = 0; y < 24; y++) begin
            for (int x = 0; x < 24; x++) begin
                int p = (y / 2) * 12 + (x / 2);
                int pos = (y % 2) * 2 + (x % 2);
                if (pos == p % 4) img[y*24 + x] = (p % 3 == 0) ? -1 : 0;
                else img[y*24 + x] = -16;
            end
        end
        do_start(1'b0, 0);
        push_golden();
        drive_image(0, 576);
        wait_check("t3");

        // 4: random data and weights, random gaps; weight address must walk 0..143
        set_weights(2);
        rand_image();
        do_start(1'b0, 0);
        push_golden();
        addr_log.delete();
        log_en = 1'b1;
        drive_image(5, 576);
        wait_check("t4");
        log_en = 1'b0;
        seq.delete();
        foreach (addr_log[i]) begin
            if (seq.size() == 0 || seq[seq.size()-1] != addr_log[i]) seq.push_back(addr_log[i]);
        end
        if (seq.size() == 145 && seq[0] == 143) void'(seq.pop_front());
        chk("t4 addr_seq len", seq.size(), 144);
        err = 0;
        foreach (seq[i]) if (seq[i] != i) err++;
        chk("t4 addr_seq order", err, 0);

        // 5: abort at input 300, then a clean image
        set_weights(2);
        rand_image();
        p0 = pulse_cnt;
        do_start(1'b0, 0);
        drive_image(0, 300);
        rand_image();
        do_start(1'b0, 0);
        push_golden();
        drive_image(2, 576);
        wait_check("t5");
        repeat (3) @(negedge clk);
        chk("t5 pulses", pulse_cnt - p0, 1);

        // 6a: extra valids after the image leave the scores alone
        rand_image();
        p0 = pulse_cnt;
        do_start(1'b0, 0);
        push_golden();
        drive_image(0, 576);
        drive_sample(15);
        drive_sample(15);
        wait_check("t6a");
        for (int i = 0; i < 20; i++) drive_sample(int'($urandom_range(31, 0)) - 16);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 10; k++)
            chk($sformatf("t6a hold score%0d", k), int'($signed(res[k])), last_exp.s[k]);
        chk("t6a pulses", pulse_cnt - p0, 1);

        // 6b: start coincident with a valid drops that sample
        rand_image();
        do_start(1'b1, 15);
        push_golden();
        drive_image(0, 576);
        wait_check("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
